bus_ctrl: RTL and testbench

Bus controller sitting directly downstream of the MMIO mmu's bus side. It captures one request (slave number, offset, data, write enable, mode), routes it to the addressed slave over a shared slave bus with one-hot request lines, and waits for that slave's acknowledge. It returns read data to the mmu with a single-cycle ready pulse. Unmapped or unresponsive slaves complete with an error flag and a fixed poison value, so the core never hangs.

---
 rtl/bus_ctrl.sv | 148 ++++++++++++++
 tb/tb_bus_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_ctrl.sv
// bus_ctrl: single-outstanding bus controller between the MMIO mmu and the
// slave bus. Captures one request in IDLE, drives a one-hot request to the
// addressed slave, waits for that slave's ack (bounded by TIMEOUT) and
// returns read data with a one-cycle bus_ready pulse. Unmapped slaves and
// timeouts complete with bus_err=1 and POISON read data.
//
// state  | meaning
// IDLE   | waiting for bus_req; captures request fields
// ACCESS | slv_req asserted to one slave, waiting for its ack or timeout
// DONE   | bus_ready pulse; bus_dat_o/bus_err valid
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   bus_req..bus_dat_i  request from mmu (sampled only in IDLE)
//   bus_dat_o, bus_ready, bus_err  completion to mmu
//   slv_req, slv_wen, slv_mode, slv_addr, slv_dat_o  registered slave bus
//   slv_dat_i, slv_ack  per-slave read data (flattened) and acknowledge
module bus_ctrl #(
  parameter int                 XLEN        = 32,
  parameter int                 SLAVE_WIDTH = 4,
  parameter int                 NSLAVE      = 16,
  parameter logic [NSLAVE-1:0]  SLAVE_MASK  = 16'h1501,
  parameter int                 TIMEOUT     = 64,
  parameter logic [XLEN-1:0]    POISON      = 32'hdeadbeef
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        bus_req,
  input  logic                        bus_wen,
  input  logic [2:0]                  bus_mode,
  input  logic [SLAVE_WIDTH-1:0]      bus_num,
  input  logic [XLEN-SLAVE_WIDTH-1:0] bus_addr,
  input  logic [XLEN-1:0]             bus_dat_i,
  output logic [XLEN-1:0]             bus_dat_o,
  output logic                        bus_ready,
  output logic                        bus_err,
  output logic [NSLAVE-1:0]           slv_req,
  output logic                        slv_wen,
  output logic [2:0]                  slv_mode,
  output logic [XLEN-SLAVE_WIDTH-1:0] slv_addr,
  output logic [XLEN-1:0]             slv_dat_o,
  input  logic [NSLAVE*XLEN-1:0]      slv_dat_i,
  input  logic [NSLAVE-1:0]           slv_ack
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                      state, state_nxt;
  logic [SLAVE_WIDTH-1:0]      num_q, num_nxt;
  logic [TW-1:0]               timer, timer_nxt;
  logic [NSLAVE-1:0]           req_nxt;
  logic                        wen_nxt;
  logic [2:0]                  mode_nxt;
  logic [XLEN-SLAVE_WIDTH-1:0] addr_nxt;
  logic [XLEN-1:0]             wdat_nxt;
  logic [XLEN-1:0]             rdat_nxt;
  logic                        err_nxt;

  // Only the captured slave's ack and data are looked at.
  logic            sel_ack;
  logic [XLEN-1:0] sel_dat;
  assign sel_ack = slv_ack[num_q];
  assign sel_dat = slv_dat_i[int'(num_q)*XLEN +: XLEN];

  // Combinational from state so reset clears it without a clock edge.
  assign bus_ready = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      num_q     <= '0;
      timer     <= '0;
      slv_req   <= '0;
      slv_wen   <= 1'b0;
      slv_mode  <= '0;
      slv_addr  <= '0;
      slv_dat_o <= '0;
      bus_dat_o <= '0;
      bus_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      num_q     <= num_nxt;
      timer     <= timer_nxt;
      slv_req   <= req_nxt;
      slv_wen   <= wen_nxt;
      slv_mode  <= mode_nxt;
      slv_addr  <= addr_nxt;
      slv_dat_o <= wdat_nxt;
      bus_dat_o <= rdat_nxt;
      bus_err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    num_nxt   = num_q;
    timer_nxt = timer;
    req_nxt   = slv_req;
    wen_nxt   = slv_wen;
    mode_nxt  = slv_mode;
    addr_nxt  = slv_addr;
    wdat_nxt  = slv_dat_o;
    rdat_nxt  = bus_dat_o;
    err_nxt   = bus_err;
    case (state)
      IDLE: begin
        if (bus_req) begin
          num_nxt  = bus_num;
          wen_nxt  = bus_wen;
          mode_nxt = bus_mode;
          addr_nxt = bus_addr;
          wdat_nxt = bus_dat_i;
          if (SLAVE_MASK[bus_num]) begin
            state_nxt        = ACCESS;
            timer_nxt        = '0;
            req_nxt          = '0;
            req_nxt[bus_num] = 1'b1;
          end else begin
            state_nxt = DONE;
            err_nxt   = 1'b1;
            rdat_nxt  = POISON;
          end
        end
      end
      ACCESS: begin
        // Ack is checked first so an ack on the last timer cycle still wins.
        if (sel_ack) begin
          state_nxt = DONE;
          req_nxt   = '0;
          err_nxt   = 1'b0;
          if (!slv_wen) rdat_nxt = sel_dat;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          state_nxt = DONE;
          req_nxt   = '0;
          err_nxt   = 1'b1;
          rdat_nxt  = POISON;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_ctrl.sv
module tb_bus_ctrl;
  localparam int          XLEN    = 32;
  localparam int          NS      = 16;
  localparam int          TIMEOUT = 64;
  localparam logic [15:0] MASK    = 16'h1501;
  localparam logic [31:0] POISON  = 32'hdeadbeef;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              bus_req = 1'b0, bus_wen = 1'b0;
  logic [2:0]        bus_mode = '0;
  logic [3:0]        bus_num = '0;
  logic [27:0]       bus_addr = '0;
  logic [31:0]       bus_dat_i = '0;
  logic [31:0]       bus_dat_o;
  logic              bus_ready, bus_err;
  logic [15:0]       slv_req;
  logic              slv_wen;
  logic [2:0]        slv_mode;
  logic [27:0]       slv_addr;
  logic [31:0]       slv_dat_o;
  logic [NS*XLEN-1:0] slv_dat_i = '0;
  logic [15:0]       slv_ack = '0;

  int vectors = 0;
  int miscompares = 0;
  bit run_cmp = 1'b0;

  bus_ctrl dut (
    .clk(clk), .rst(rst), .bus_req(bus_req), .bus_wen(bus_wen),
    .bus_mode(bus_mode), .bus_num(bus_num), .bus_addr(bus_addr),
    .bus_dat_i(bus_dat_i), .bus_dat_o(bus_dat_o), .bus_ready(bus_ready),
    .bus_err(bus_err), .slv_req(slv_req), .slv_wen(slv_wen),
    .slv_mode(slv_mode), .slv_addr(slv_addr), .slv_dat_o(slv_dat_o),
    .slv_dat_i(slv_dat_i), .slv_ack(slv_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: a request is taken only when no transaction
  // is in flight and at least one idle cycle followed the last completion;
  // completion happens on the first edge with the target's ack, or TIMEOUT
  // edges after capture. bus_ready is high in the cycle after completion.
  int               cyc = 0, cap_cyc = 0, done_cyc = -10;
  bit               busy = 1'b0;
  logic [3:0]       m_num = '0;
  logic [15:0]      e_req = '0;
  logic             e_err = 1'b0, e_wen = 1'b0;
  logic [31:0]      e_dat = '0, e_wdat = '0;
  logic [2:0]       e_mode = '0;
  logic [27:0]      e_addr = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0; done_cyc <= cyc - 10; e_req <= '0; e_err <= 1'b0;
      e_dat <= '0; e_wen <= 1'b0; e_mode <= '0; e_addr <= '0; e_wdat <= '0;
    end else begin
      cyc <= cyc + 1;
      if (busy) begin
        if (slv_ack[m_num]) begin
          busy <= 1'b0; done_cyc <= cyc + 1; e_req <= '0; e_err <= 1'b0;
          if (!e_wen) e_dat <= slv_dat_i[m_num*XLEN +: XLEN];
        end else if ((cyc + 1) - cap_cyc == TIMEOUT) begin
          busy <= 1'b0; done_cyc <= cyc + 1; e_req <= '0; e_err <= 1'b1;
          e_dat <= POISON;
        end
      end else if (bus_req && (cyc + 1 >= done_cyc + 2)) begin
        cap_cyc <= cyc + 1; m_num <= bus_num;
        e_wen <= bus_wen; e_mode <= bus_mode; e_addr <= bus_addr; e_wdat <= bus_dat_i;
        if (MASK[bus_num]) begin
          busy  <= 1'b1;
          e_req <= 16'(32'd1 << bus_num);
        end else begin
          done_cyc <= cyc + 1; e_err <= 1'b1; e_dat <= POISON;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp && !rst) begin
      chk("m_ready",    32'(bus_ready), 32'(cyc == done_cyc));
      chk("m_err",      32'(bus_err),   32'(e_err));
      chk("m_dat_o",    bus_dat_o,      e_dat);
      chk("m_slv_req",  32'(slv_req),   32'(e_req));
      chk("m_slv_wen",  32'(slv_wen),   32'(e_wen));
      chk("m_slv_mode", 32'(slv_mode),  32'(e_mode));
      chk("m_slv_addr", 32'(slv_addr),  32'(e_addr));
      chk("m_slv_dat",  slv_dat_o,      e_wdat);
    end
  end

  // Starts at a negedge with the DUT idle; returns at a negedge back in IDLE.
  task automatic run_txn(input logic [3:0] num, input logic wen, input logic [27:0] addr,
                         input logic [31:0] wdat, input int ack_at, input logic [15:0] noise,
                         output int lat, output int req_cyc);
    logic [15:0] onehot;
    onehot = 16'(32'd1 << num);
    bus_req = 1'b1; bus_num = num; bus_wen = wen; bus_addr = addr;
    bus_dat_i = wdat; bus_mode = 3'd2; slv_ack = '0;
    @(negedge clk);
    // Changes after capture must have no effect.
    bus_req = 1'b0; bus_wen = ~wen; bus_addr = ~addr; bus_dat_i = ~wdat; bus_num = ~num;
    lat = 0; req_cyc = 0;
    for (int k = 0; k < 200; k++) begin
      if (slv_req != '0) begin
        req_cyc++;
        chk("stable_req",  32'(slv_req),  32'(onehot));
        chk("stable_addr", 32'(slv_addr), 32'(addr));
        chk("stable_wdat", slv_dat_o,     wdat);
        chk("stable_wen",  32'(slv_wen),  32'(wen));
      end
      if (bus_ready) begin
        lat = k + 1;
        break;
      end
      slv_ack = noise | ((k == ack_at) ? onehot : 16'h0);
      @(negedge clk);
    end
    slv_ack = '0;
    if (lat == 0) chk("txn_bound", 32'd0, 32'd1);
    @(negedge clk);
    chk("ready_pulse", 32'(bus_ready), 32'd0);
  endtask

  int lat, rc;

  initial begin
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req",   32'(slv_req),   32'd0);
    chk("rst_ready", 32'(bus_ready), 32'd0);
    chk("rst_err",   32'(bus_err),   32'd0);
    chk("rst_dat",   bus_dat_o,      32'd0);
    rst = 1'b0;
    run_cmp = 1'b1;
    @(negedge clk);

    // Read slave 8, ack on first ACCESS cycle.
    slv_dat_i[8*XLEN +: XLEN] = 32'h12345678;
    run_txn(4'h8, 1'b0, 28'h0000040, 32'h0, 0, 16'h0, lat, rc);
    chk("rd8_lat", 32'(lat), 32'd2);
    chk("rd8_req_cycles", 32'(rc), 32'd1);
    chk("rd8_dat", bus_dat_o, 32'h12345678);
    chk("rd8_err", 32'(bus_err), 32'd0);

    // Write slave 0xc, ack delayed 5 cycles; read data left unchanged.
    run_txn(4'hc, 1'b1, 28'h0000010, 32'hcafef00d, 5, 16'h0, lat, rc);
    chk("wrc_lat", 32'(lat), 32'd7);
    chk("wrc_req_cycles", 32'(rc), 32'd6);
    chk("wrc_dat_hold", bus_dat_o, 32'h12345678);
    chk("wrc_err", 32'(bus_err), 32'd0);

    // Unmapped slave 3.
    run_txn(4'h3, 1'b0, 28'h0000100, 32'h0, 0, 16'h0, lat, rc);
    chk("un3_lat", 32'(lat), 32'd1);
    chk("un3_req_cycles", 32'(rc), 32'd0);
    chk("un3_dat", bus_dat_o, POISON);
    chk("un3_err", 32'(bus_err), 32'd1);

    // Slave 0 never acks.
    run_txn(4'h0, 1'b0, 28'h0000004, 32'h0, -1, 16'h0, lat, rc);
    chk("to0_lat", 32'(lat), 32'(TIMEOUT + 1));
    chk("to0_req_cycles", 32'(rc), 32'(TIMEOUT));
    chk("to0_dat", bus_dat_o, POISON);
    chk("to0_err", 32'(bus_err), 32'd1);

    // Slave 8 addressed, slave 10 acking throughout; own ack on last cycle.
    slv_dat_i[8*XLEN +: XLEN] = 32'h0badf00d;
    slv_dat_i[10*XLEN +: XLEN] = 32'h11111111;
    run_txn(4'h8, 1'b0, 28'h0000008, 32'h0, TIMEOUT - 1, 16'h0400, lat, rc);
    chk("last_lat", 32'(lat), 32'(TIMEOUT + 1));
    chk("last_dat", bus_dat_o, 32'h0badf00d);
    chk("last_err", 32'(bus_err), 32'd0);

    // Reset in the middle of ACCESS after an error completion.
    run_txn(4'h3, 1'b0, 28'h0, 32'h0, 0, 16'h0, lat, rc);
    bus_req = 1'b1; bus_num = 4'h0; bus_wen = 1'b0;
    @(negedge clk);
    bus_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_req", 32'(slv_req), 32'h0001);
    #2 rst = 1'b1;
    #1;
    chk("arst_req",   32'(slv_req),   32'd0);
    chk("arst_ready", 32'(bus_ready), 32'd0);
    chk("arst_err",   32'(bus_err),   32'd0);
    chk("arst_dat",   bus_dat_o,      32'd0);
    @(negedge clk);
    rst = 1'b0;
    slv_dat_i[10*XLEN +: XLEN] = 32'h0a0a0a0a;
    run_txn(4'ha, 1'b0, 28'h0000020, 32'h0, 1, 16'h0, lat, rc);
    chk("post_rst_lat", 32'(lat), 32'd3);
    chk("post_rst_dat", bus_dat_o, 32'h0a0a0a0a);

    // Random traffic checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      bus_req   = ($urandom_range(0, 3) != 0);
      bus_num   = 4'($urandom);
      bus_wen   = 1'($urandom);
      bus_mode  = 3'($urandom);
      bus_addr  = 28'($urandom);
      bus_dat_i = $urandom;
      slv_ack   = 16'($urandom & $urandom & $urandom);
      for (int s = 0; s < NS; s++) slv_dat_i[s*XLEN +: XLEN] = $urandom;
      @(negedge clk);
    end
    bus_req = 1'b0;
    slv_ack = '0;
    @(negedge clk);
    run_cmp = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
